udma_tx_word_packer: RTL and testbench
======================================

Name: udma_tx_word_packer

Overview:
- Transmit-direction counterpart of the uDMA external-peripheral RX path.
- Accepts a stream of 32-bit words from the L2 TX channel and packs each consecutive pair into one 64-bit beat for the TX dual-clock FIFO.
- Packing is little-endian: the first word goes to [31:0], the second to [63:32].
- Each transfer has a programmed word count. An odd count is completed with a pad word, and the final beat is flagged as last.

Parameters:
- TRANS_SIZE, 16: width of the transfer length in 32-bit words.
- PAD_WORD, 32'h0000_0000: value placed in [63:32] of the final beat of an odd-length transfer.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_start_i  in  1  single-cycle pulse that starts a transfer; sampled only in IDLE.
- cfg_len_i  in  TRANS_SIZE  transfer length in 32-bit words; sampled with cfg_start_i.
- cfg_busy_o  out  1  high from the cycle after an accepted start until the end-of-transfer pulse.
- eot_o  out  1  single-cycle end-of-transfer pulse.
- data_tx_rdata_i  in  32  word from L2.
- data_tx_valid_i  in  1  word valid.
- data_tx_ready_o  out  1  word accepted when valid and ready are both high.
- data_tx_wdata_o  out  64  packed beat to the DC FIFO.
- data_tx_valid_o  out  1  beat valid.
- data_tx_last_o  out  1  final beat of the transfer; qualified by data_tx_valid_o.
- data_tx_ready_i  in  1  FIFO ready.

Behaviour:
- Reset values:
  - All outputs are 0: cfg_busy_o, eot_o, data_tx_ready_o, data_tx_valid_o, data_tx_last_o, data_tx_wdata_o.
  - State is IDLE; remaining-word counter, low-word register and output register are cleared.
  - Reset is asynchronous and may occur mid-transfer. Any partial word and any pending beat are discarded, and no eot_o is generated.
- Internal storage:
  - lo_q: 32-bit low-word register.
  - out register: 64-bit data, a valid bit and a last bit.
  - rem: TRANS_SIZE-bit count of words still to be accepted.
- out_free = ~data_tx_valid_o | data_tx_ready_i. A beat may be loaded in the same cycle the current beat drains.
- Output register:
  - It drives data_tx_wdata_o, data_tx_valid_o and data_tx_last_o directly; there is no combinational path from input to output.
  - data_tx_valid_o clears on a handshake unless a new beat is loaded in the same cycle.
  - Held data stays stable while valid is high and ready is low.
- State machine: IDLE, LOW, HIGH, FLUSH, DRAIN.
  - IDLE:
    - data_tx_ready_o = 0.
    - cfg_start_i with cfg_len_i != 0: rem <= cfg_len_i, go to LOW.
    - cfg_start_i with cfg_len_i == 0: eot_o = 1 in the next cycle and stay in IDLE. No beat is produced and cfg_busy_o stays 0.
  - LOW:
    - data_tx_ready_o = 1. lo_q is free because pairs are handed off in HIGH.
    - On a handshake: lo_q <= rdata and rem decrements.
    - If rem was 1, go to FLUSH; otherwise go to HIGH.
  - HIGH:
    - data_tx_ready_o = out_free.
    - On a handshake: load the beat {rdata, lo_q} and decrement rem.
    - last = (rem was 1).
    - If last, go to DRAIN; otherwise go to LOW.
  - FLUSH:
    - data_tx_ready_o = 0.
    - When out_free: load the beat {PAD_WORD, lo_q} with last = 1, then go to DRAIN.
  - DRAIN:
    - data_tx_ready_o = 0.
    - When the final beat handshakes, or data_tx_valid_o is already 0: assert eot_o for exactly one cycle (registered, the following cycle) and go to IDLE.
- cfg_busy_o is high in LOW, HIGH, FLUSH and DRAIN.
- cfg_start_i outside IDLE is ignored; it does not change rem or state.
- Latency:
  - From high-word handshake to data_tx_valid_o is 1 cycle.
  - From final beat handshake to eot_o is 1 cycle.
- Throughput: sustains one 32-bit word per cycle, i.e. one 64-bit beat every 2 cycles, while data_tx_ready_i is held high.
- Input stall:
  - data_tx_valid_i low in any state causes no state change and no counter change.
  - Words arriving while in IDLE are never accepted.
- Length cfg_len_i = 2^TRANS_SIZE−1 (maximum) must work with no counter wrap. rem only decrements on handshake and never goes below 0.

Test Plan:
- Length 4, words 0x11,0x22,0x33,0x44 with no stalls and ready always 1:
  - Beats 0x00000022_00000011 (last=0) and 0x00000044_00000033 (last=1) at cycles +2 and +4.
  - eot_o one cycle after the second beat; busy drops in the same cycle.
- Length 3, words A,B,C, PAD_WORD=0:
  - Beats {B,A} (last=0) and {0x0,C} (last=1).
  - Only 3 input handshakes; data_tx_ready_o=0 after C.
- Back-pressure, length 6:
  - Hold data_tx_ready_i=0 for 5 cycles after the first beat.
  - Beat 1 stays stable and data_tx_ready_o=0 in HIGH.
  - After release, all 3 beats are delivered in order with no loss or duplication.
- cfg_len_i=0: no data_tx_valid_o, no input accepted, eot_o pulses once one cycle after start.
- Start while busy: a second cfg_start_i with len 8 during a length-2 transfer is ignored. Exactly 1 beat is produced and one eot_o.
- Reset mid-transfer: assert rst_n=0 in HIGH with a beat pending.
  - All outputs go to 0 immediately.
  - After release a fresh length-2 transfer produces exactly one correct beat with last=1.

Source files
------------

// File: rtl/udma_tx_word_packer_if.sv
// ---------------------------------------------------------------------------
// udma_tx_word_packer_if
// Groups the two streaming sides of the TX word packer:
//   L2 side  : data_tx_rdata_i (32b word), data_tx_valid_i, data_tx_ready_o
//   FIFO side: data_tx_wdata_o (64b beat), data_tx_valid_o, data_tx_last_o,
//              data_tx_ready_i
// Signal names keep the packer's point of view (_i = into the packer).
// modport slave  : used by the packer itself.
// modport master : used by whatever drives words in and drains beats out.
// ---------------------------------------------------------------------------
interface udma_tx_word_packer_if;
    logic [31:0] data_tx_rdata_i;
    logic        data_tx_valid_i;
    logic        data_tx_ready_o;
    logic [63:0] data_tx_wdata_o;
    logic        data_tx_valid_o;
    logic        data_tx_last_o;
    logic        data_tx_ready_i;

    modport slave (
        input  data_tx_rdata_i,
        input  data_tx_valid_i,
        output data_tx_ready_o,
        output data_tx_wdata_o,
        output data_tx_valid_o,
        output data_tx_last_o,
        input  data_tx_ready_i
    );

    modport master (
        output data_tx_rdata_i,
        output data_tx_valid_i,
        input  data_tx_ready_o,
        input  data_tx_wdata_o,
        input  data_tx_valid_o,
        input  data_tx_last_o,
        output data_tx_ready_i
    );
endinterface

// File: rtl/udma_tx_word_packer.sv
// ---------------------------------------------------------------------------
// udma_tx_word_packer
// Packs a stream of 32-bit L2 words into 64-bit little-endian beats for the
// TX dual-clock FIFO (first word in [31:0], second in [63:32]). Each transfer
// has a programmed word count; an odd count is closed with PAD_WORD in the
// upper half of the final beat, and the final beat carries last.
//
// Ports:
//   sys_clk, rst_n  : clock, asynchronous active-low reset
//   cfg_start_i     : one-cycle start pulse, only honoured in IDLE
//   cfg_len_i       : transfer length in words, sampled with cfg_start_i
//   cfg_busy_o      : transfer in progress
//   eot_o           : one-cycle end-of-transfer pulse
//   tx              : word input / beat output streams (see the interface)
// ---------------------------------------------------------------------------
module udma_tx_word_packer #(
    parameter int unsigned TRANS_SIZE = 16,
    parameter logic [31:0] PAD_WORD   = 32'h0000_0000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cfg_start_i,
    input  logic [TRANS_SIZE-1:0] cfg_len_i,
    output logic                  cfg_busy_o,
    output logic                  eot_o,
    udma_tx_word_packer_if.slave  tx
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [TRANS_SIZE-1:0] REM_ZERO = {TRANS_SIZE{1'b0}};
    localparam logic [TRANS_SIZE-1:0] REM_ONE  = {{(TRANS_SIZE-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [TRANS_SIZE-1:0] rem_q, rem_d;
    logic [31:0]           lo_q, lo_d;
    logic [63:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  eot_q, eot_d;
    logic                  busy_q, busy_d;

    logic                  out_free;
    logic                  word_ready;
    logic                  word_hs;

    // The output slot can take a new beat when empty or draining this cycle.
    assign out_free = ~valid_q | tx.data_tx_ready_i;

    // Word-side ready: only the HIGH half depends on the output slot, because
    // a high-word handshake immediately loads a beat.
    always_comb begin
        word_ready = 1'b0;
        case (state_q)
            ST_LOW:  word_ready = 1'b1;
            ST_HIGH: word_ready = out_free;
            default: word_ready = 1'b0;
        endcase
    end

    assign word_hs = tx.data_tx_valid_i & word_ready;

    // Next-state, counter, low-word and output-register logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        eot_d   = 1'b0;

        // A beat leaving the slot frees it; a load below overrides this.
        if (valid_q && tx.data_tx_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
            last_d  = last_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_len_i != REM_ZERO) begin
                        rem_d   = cfg_len_i;
                        state_d = ST_LOW;
                    end else begin
                        // Empty transfer: report completion without any beat.
                        eot_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (word_hs) begin
                    lo_d  = tx.data_tx_rdata_i;
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (word_hs) begin
                    data_d  = {tx.data_tx_rdata_i, lo_q};
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOW;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    data_d  = {PAD_WORD, lo_q};
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // out_free here means the last beat is leaving or already gone.
                if (out_free) begin
                    eot_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered busy mirrors the state register exactly.
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset discards any partial transfer.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= REM_ZERO;
            lo_q    <= 32'h0000_0000;
            data_q  <= 64'h0000_0000_0000_0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            eot_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            eot_q   <= eot_d;
            busy_q  <= busy_d;
        end
    end

    assign tx.data_tx_ready_o = word_ready;
    assign tx.data_tx_wdata_o = data_q;
    assign tx.data_tx_valid_o = valid_q;
    assign tx.data_tx_last_o  = last_q;
    assign cfg_busy_o         = busy_q;
    assign eot_o              = eot_q;

endmodule

// File: tb/tb_udma_tx_word_packer.sv
module tb_udma_tx_word_packer;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start_i = 1'b0;
    logic [15:0] cfg_len_i = 16'd0;
    logic        cfg_busy_o;
    logic        eot_o;

    udma_tx_word_packer_if bus();

    udma_tx_word_packer #(.TRANS_SIZE(16), .PAD_WORD(32'h0000_0000)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cfg_start_i(cfg_start_i),
        .cfg_len_i  (cfg_len_i),
        .cfg_busy_o (cfg_busy_o),
        .eot_o      (eot_o),
        .tx         (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int in_cnt = 0;
    int eot_cnt = 0;
    logic [64:0] beats[$];
    logic [31:0] wq[$];

    // Monitor: inputs only change just after posedge, so the negedge view
    // equals what the next posedge will see.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (bus.data_tx_valid_i && bus.data_tx_ready_o) in_cnt <= in_cnt + 1;
            if (eot_o) eot_cnt <= eot_cnt + 1;
            if (bus.data_tx_valid_o && bus.data_tx_ready_i)
                beats.push_back({bus.data_tx_last_o, bus.data_tx_wdata_o});
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Present each word of wq until accepted, bounded per word.
    task automatic feed_words(output bit ok);
        bit taken;
        ok = 1'b1;
        foreach (wq[i]) begin
            taken = 1'b0;
            bus.data_tx_rdata_i = wq[i];
            bus.data_tx_valid_i = 1'b1;
            for (int c = 0; c < 50 && !taken; c++) begin
                @(negedge sys_clk);
                taken = bus.data_tx_ready_o;
                @(posedge sys_clk);
                #1;
            end
            if (!taken) ok = 1'b0;
        end
        bus.data_tx_valid_i = 1'b0;
    endtask

    task automatic wait_eot(input int base, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick();
            if (eot_cnt != base) ok = 1'b1;
        end
    endtask

    task automatic start(input logic [15:0] len);
        cfg_start_i = 1'b1;
        cfg_len_i   = len;
        tick();
        cfg_start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_tx_valid_i = 1'b0;
        bus.data_tx_rdata_i = 32'h0;
        bus.data_tx_ready_i = 1'b1;
        tick(); tick();
        checks++;
        if ({cfg_busy_o, eot_o, bus.data_tx_ready_o, bus.data_tx_valid_o, bus.data_tx_last_o} !== 5'b0 ||
            bus.data_tx_wdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b eot=%0b rdy=%0b v=%0b l=%0b d=%h, want all 0",
                     cfg_busy_o, eot_o, bus.data_tx_ready_o, bus.data_tx_valid_o, bus.data_tx_last_o, bus.data_tx_wdata_o);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.data_tx_ready_o !== 1'b0 || cfg_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%0b busy=%0b, want 0 0", bus.data_tx_ready_o, cfg_busy_o);
        end
    endtask

    task automatic test_len4_stream();
        bus.data_tx_ready_i = 1'b1;
        bus.data_tx_rdata_i = 32'h11;
        bus.data_tx_valid_i = 1'b1;
        start(16'd4);                               // edge 0: start sampled
        checks++;
        if (cfg_busy_o !== 1'b1 || bus.data_tx_ready_o !== 1'b1 || bus.data_tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_low: got busy=%0b rdy=%0b v=%0b, want 1 1 0", cfg_busy_o, bus.data_tx_ready_o, bus.data_tx_valid_o);
        end
        tick();                                     // edge 1: 0x11
        bus.data_tx_rdata_i = 32'h22;
        tick();                                     // edge 2: 0x22 -> beat
        checks++;
        if (bus.data_tx_valid_o !== 1'b1 || bus.data_tx_wdata_o !== 64'h00000022_00000011 || bus.data_tx_last_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_beat1: got v=%0b d=%h l=%0b, want 1 0000002200000011 0",
                     bus.data_tx_valid_o, bus.data_tx_wdata_o, bus.data_tx_last_o);
        end
        bus.data_tx_rdata_i = 32'h33;
        tick();                                     // edge 3: 0x33, beat1 drained
        checks++;
        if (bus.data_tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_gap: got v=%0b, want 0", bus.data_tx_valid_o);
        end
        bus.data_tx_rdata_i = 32'h44;
        tick();                                     // edge 4: 0x44 -> last beat
        bus.data_tx_valid_i = 1'b0;
        checks++;
        if (bus.data_tx_valid_o !== 1'b1 || bus.data_tx_wdata_o !== 64'h00000044_00000033 ||
            bus.data_tx_last_o !== 1'b1 || cfg_busy_o !== 1'b1 || eot_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_beat2: got v=%0b d=%h l=%0b busy=%0b eot=%0b, want 1 0000004400000033 1 1 0",
                     bus.data_tx_valid_o, bus.data_tx_wdata_o, bus.data_tx_last_o, cfg_busy_o, eot_o);
        end
        tick();                                     // edge 5: drain -> eot
        checks++;
        if (eot_o !== 1'b1 || cfg_busy_o !== 1'b0 || bus.data_tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_eot: got eot=%0b busy=%0b v=%0b, want 1 0 0", eot_o, cfg_busy_o, bus.data_tx_valid_o);
        end
        tick();
        checks++;
        if (eot_o !== 1'b0) begin
            errors++;
            $display("FAIL l4_eot_pulse: got eot=%0b, want 0", eot_o);
        end
    endtask

    task automatic test_odd_pad();
        bit ok;
        int in0, e0;
        beats.delete();
        in0 = in_cnt; e0 = eot_cnt;
        bus.data_tx_ready_i = 1'b1;
        start(16'd3);
        wq = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        feed_words(ok);
        checks++;
        if (!ok || bus.data_tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL odd_feed: got ok=%0b rdy_after_C=%0b, want 1 0", ok, bus.data_tx_ready_o);
        end
        wait_eot(e0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL odd_eot_timeout: got no eot, want eot"); end
        checks++;
        if (beats.size() != 2 || in_cnt - in0 != 3) begin
            errors++;
            $display("FAIL odd_counts: got beats=%0d words=%0d, want 2 3", beats.size(), in_cnt - in0);
        end else begin
            checks++;
            if (beats[0] !== {1'b0, 64'hBBBB0002_AAAA0001} || beats[1] !== {1'b1, 64'h00000000_CCCC0003}) begin
                errors++;
                $display("FAIL odd_beats: got %h %h, want 0bbbb0002aaaa0001 100000000cccc0003", beats[0], beats[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int e0;
        logic [64:0] exp [3];
        beats.delete();
        e0 = eot_cnt;
        bus.data_tx_ready_i = 1'b0;
        bus.data_tx_rdata_i = 32'h10000000;
        bus.data_tx_valid_i = 1'b1;
        start(16'd6);
        tick();                                     // w0 accepted
        bus.data_tx_rdata_i = 32'h10000001;
        tick();                                     // w1 -> beat 1
        bus.data_tx_rdata_i = 32'h10000002;
        tick();                                     // w2 accepted, now HIGH
        bus.data_tx_rdata_i = 32'h10000003;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.data_tx_valid_o !== 1'b1 || bus.data_tx_wdata_o !== 64'h10000001_10000000 || bus.data_tx_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%0b d=%h rdy=%0b, want 1 1000000110000000 0",
                         i, bus.data_tx_valid_o, bus.data_tx_wdata_o, bus.data_tx_ready_o);
            end
            tick();
        end
        bus.data_tx_ready_i = 1'b1;
        wq = '{32'h10000003, 32'h10000004, 32'h10000005};
        feed_words(ok);
        wait_eot(e0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_eot_timeout: got no eot, want eot"); end
        exp[0] = {1'b0, 64'h10000001_10000000};
        exp[1] = {1'b0, 64'h10000003_10000002};
        exp[2] = {1'b1, 64'h10000005_10000004};
        checks++;
        if (beats.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, want 3", beats.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h, want %h", i, beats[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int in0;
        beats.delete();
        in0 = in_cnt;
        bus.data_tx_ready_i = 1'b1;
        bus.data_tx_rdata_i = 32'hDEAD0000;
        bus.data_tx_valid_i = 1'b1;
        start(16'd0);
        checks++;
        if (eot_o !== 1'b1 || cfg_busy_o !== 1'b0 || bus.data_tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_eot: got eot=%0b busy=%0b rdy=%0b, want 1 0 0", eot_o, cfg_busy_o, bus.data_tx_ready_o);
        end
        for (int i = 0; i < 4; i++) tick();
        bus.data_tx_valid_i = 1'b0;
        checks++;
        if (eot_o !== 1'b0 || beats.size() != 0 || in_cnt != in0) begin
            errors++;
            $display("FAIL zero_quiet: got eot=%0b beats=%0d words=%0d, want 0 0 0", eot_o, beats.size(), in_cnt - in0);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int in0, e0;
        beats.delete();
        in0 = in_cnt; e0 = eot_cnt;
        bus.data_tx_ready_i = 1'b1;
        bus.data_tx_rdata_i = 32'h000000D1;
        bus.data_tx_valid_i = 1'b1;
        start(16'd2);
        cfg_start_i = 1'b1;
        cfg_len_i   = 16'd8;
        tick();                                     // D1 accepted, start ignored
        cfg_start_i = 1'b0;
        bus.data_tx_rdata_i = 32'h000000D2;
        tick();                                     // D2 -> final beat
        bus.data_tx_valid_i = 1'b0;
        wait_eot(e0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_eot_timeout: got no eot, want eot"); end
        bus.data_tx_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.data_tx_valid_i = 1'b0;
        checks++;
        if (beats.size() != 1 || eot_cnt - e0 != 1 || in_cnt - in0 != 2 || cfg_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_counts: got beats=%0d eots=%0d words=%0d busy=%0b, want 1 1 2 0",
                     beats.size(), eot_cnt - e0, in_cnt - in0, cfg_busy_o);
        end else begin
            checks++;
            if (beats[0] !== {1'b1, 64'h000000D2_000000D1}) begin
                errors++;
                $display("FAIL busy_beat: got %h, want 1000000d2000000d1", beats[0]);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        int e0;
        bus.data_tx_ready_i = 1'b0;
        bus.data_tx_rdata_i = 32'h00000A0;
        bus.data_tx_valid_i = 1'b1;
        start(16'd4);
        tick();
        bus.data_tx_rdata_i = 32'h00000A1;
        tick();                                     // beat pending
        bus.data_tx_rdata_i = 32'h00000A2;
        tick();                                     // now HIGH
        bus.data_tx_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_busy_o, eot_o, bus.data_tx_ready_o, bus.data_tx_valid_o, bus.data_tx_last_o} !== 5'b0 ||
            bus.data_tx_wdata_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%0b eot=%0b rdy=%0b v=%0b l=%0b d=%h, want all 0",
                     cfg_busy_o, eot_o, bus.data_tx_ready_o, bus.data_tx_valid_o, bus.data_tx_last_o, bus.data_tx_wdata_o);
        end
        tick();
        rst_n = 1'b1;
        bus.data_tx_ready_i = 1'b1;
        tick();
        beats.delete();
        e0 = eot_cnt;
        start(16'd2);
        wq = '{32'hCAFE0001, 32'hCAFE0002};
        feed_words(ok);
        wait_eot(e0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_eot_timeout: got no eot, want eot"); end
        tick(); tick();
        checks++;
        if (beats.size() != 1 || eot_cnt - e0 != 1) begin
            errors++;
            $display("FAIL rst_counts: got beats=%0d eots=%0d, want 1 1", beats.size(), eot_cnt - e0);
        end else begin
            checks++;
            if (beats[0] !== {1'b1, 64'hCAFE0002_CAFE0001}) begin
                errors++;
                $display("FAIL rst_beat: got %h, want 1cafe0002cafe0001", beats[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_len4_stream();
        test_odd_pad();
        test_backpressure();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
